irq_wb8: RTL and testbench
==========================

# irq_wb8

Eight-input interrupt controller on the 8-bit Wishbone I/O bus, mapped as a 4-register peripheral. It synchronises raw interrupt sources: push buttons, and the timer/UART/SPI event lines. Selected sources are debounced. Sources are latched into a pending register, and the combined request drives the CPU's INTERRUPT_I. The CPU reads pending causes, masks them, and clears them through the bus.

## Interface
- DEBOUNCE_CYCLES, 25000: sample period in clock cycles for debounced sources (1 ms at 25 MHz); must be ≥ 2; prescaler width $clog2(DEBOUNCE_CYCLES).
- DEBOUNCE_MASK, 8'h0F: bit i = 1 → source i debounced; 0 → synchroniser output used directly.

- CLK_I  in  1  single clock, all logic rising-edge.
- RST_I  in  1  reset, asynchronous, active-low; clears all state immediately.
- ADR_I  in  2  register select.
- DAT_I  in  8  write data.
- STB_I  in  1  bus strobe (already decoded by the arbiter).
- WE_I  in  1  1 = write, 0 = read.
- DAT_O  out  8  read data, registered.
- ACK_O  out  1  bus acknowledge, registered.
- I_irq  in  8  raw asynchronous interrupt sources.
- O_interrupt  out  1  registered request to CPU, active-high.

## Operation
- Input path per source: 2-flop synchroniser (sync1, sync2), then filtered level filt[i].
  - Non-debounced source: filt[i] = sync2[i].
  - Debounced source: shared prescaler counts 0..DEBOUNCE_CYCLES-1 and strobes on the terminal count.
  - On each strobe: samp[i] <= sync2[i]; if sync2[i] == samp[i], then filt[i] <= sync2[i].
  - Net effect: a level must be stable across two consecutive strobes to propagate.
- filt_d register holds filt delayed one cycle; rise[i] = filt[i] & ~filt_d[i].
- Registers (ADR_I):
  - 0 LEVEL: RO, filt[7:0]; writes ignored.
  - 1 PENDING: read returns pending; write is W1C (bit set in DAT_I clears pending bit).
  - 2 ENABLE: RW mask.
  - 3 EDGE: RW mode; 1 = rising-edge sticky, 0 = level-sensitive.
- Pending update per cycle:
  - EDGE[i]=1: pending[i] <= rise[i] | (pending[i] & ~clr[i]). A set and a clear in the same cycle resolve to set.
  - EDGE[i]=0: pending[i] <= filt[i]; W1C has no effect.
  - Changing EDGE[i] 1→0: pending follows level from the next cycle.
  - Changing EDGE[i] 0→1: pending keeps its current value until cleared or re-set.
- O_interrupt <= |(pending & ENABLE), evaluated every cycle from current register values.

## Timing
- Reset values:
  - Outputs and data path: DAT_O=0, ACK_O=0, O_interrupt=0.
  - Input path: sync1/sync2/samp/filt/filt_d = 0, prescaler = 0.
  - Registers: PENDING = 0, ENABLE = 0, EDGE = 8'hFF.
- Bus handshake:
  - A new access is taken when STB_I=1 and ACK_O=0.
  - On that edge: the write takes effect, or DAT_O is loaded; ACK_O <= 1.
  - ACK_O <= 0 on the next edge regardless of STB_I, so every access is exactly 2 cycles and back-to-back strobes ack every other cycle.
  - A write executes exactly once per access.
  - DAT_O holds its last value when not acking.
- Reads return register state sampled on the access edge; a W1C and a read in consecutive accesses see the cleared value.
- Latency, non-debounced source: I_irq rises before edge N.
  - Pending set after edge N+2.
  - O_interrupt high after edge N+3 (if enabled).
- Latency, debounced source: the first strobe after sync2 changes loads samp; the second strobe loads filt.
  - Pending is set 1 cycle later; O_interrupt 1 cycle after that.
  - Worst case ≈ 2·DEBOUNCE_CYCLES + 4 cycles.
- A glitch shorter than one strobe interval on a debounced source never reaches filt.
- ENABLE write → O_interrupt reflects the new mask one cycle after the write edge.
- Asynchronous reset mid-access drops ACK_O immediately; any write in flight is lost.

## Test plan
- Reset: assert RST_I low mid-run → all outputs 0 asynchronously; after release, read EDGE=8'hFF, ENABLE=8'h00, PENDING=8'h00.
- Edge capture, DEBOUNCE_MASK=8'h00:
  - Write ENABLE=8'h10, pulse I_irq[4] high for 1 cycle at edge N → PENDING=8'h10 after N+2, O_interrupt=1 after N+3.
  - W1C 8'h10 → O_interrupt=0 one cycle after the write ack.
- Simultaneous set/clear: time a W1C of bit 4 to land on the same edge as a new rise on I_irq[4] → PENDING bit 4 remains 1.
- Debounce, DEBOUNCE_CYCLES=4, DEBOUNCE_MASK=8'h01:
  - 3-cycle glitch on I_irq[0] → PENDING stays 0.
  - 12-cycle high → PENDING[0]=1 within 12 cycles of the input rising.
- Level mode: write EDGE=8'hFE, hold I_irq[0]=1 (debounced) → PENDING[0]=1 and is not clearable by W1C; drop I_irq[0] → PENDING[0] follows to 0 after the debounce delay.
- Bus protocol:
  - Hold STB_I high for 6 cycles with WE_I=1 to ENABLE → ACK_O pulses on cycles 1, 3, 5; the ENABLE value matches the last data.
  - Read of LEVEL returns the filt value; a write to LEVEL is ignored.

Source files
------------

// File: rtl/irq_wb8.sv
// Eight-input interrupt controller on the 8-bit Wishbone I/O bus.
// Synchronises, optionally debounces, and latches sources into a maskable pending register.
module irq_wb8 #(
    parameter int unsigned DEBOUNCE_CYCLES = 25000,
    parameter logic [7:0]  DEBOUNCE_MASK   = 8'h0F
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [1:0] ADR_I,
    input  logic [7:0] DAT_I,
    input  logic       STB_I,
    input  logic       WE_I,
    output logic [7:0] DAT_O,
    output logic       ACK_O,
    input  logic [7:0] I_irq,
    output logic       O_interrupt
);

    localparam int unsigned   PW         = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADR_LEVEL   = 2'd0;
    localparam logic [1:0] ADR_PENDING = 2'd1;
    localparam logic [1:0] ADR_ENABLE  = 2'd2;
    localparam logic [1:0] ADR_EDGE    = 2'd3;

    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    samp;
    logic [7:0]    filt_q;
    logic [7:0]    filt_d;
    logic [PW-1:0] presc;
    logic [7:0]    pending;
    logic [7:0]    enable;
    logic [7:0]    edge_mode;

    logic          strobe_c;
    logic [7:0]    filt_c;
    logic [7:0]    rise_c;
    logic          take_c;
    logic [7:0]    clr_c;
    logic [7:0]    rd_data_c;

    assign strobe_c = (presc == PRESC_LAST);
    assign filt_c   = (filt_q & DEBOUNCE_MASK) | (sync2 & ~DEBOUNCE_MASK);
    assign rise_c   = filt_c & ~filt_d;
    assign take_c   = STB_I & ~ACK_O;
    assign clr_c    = (take_c && WE_I && (ADR_I == ADR_PENDING)) ? DAT_I : 8'h00;

    // Read mux over current register state
    always_comb begin
        rd_data_c = 8'h00;
        case (ADR_I)
            ADR_LEVEL:   rd_data_c = filt_c;
            ADR_PENDING: rd_data_c = pending;
            ADR_ENABLE:  rd_data_c = enable;
            ADR_EDGE:    rd_data_c = edge_mode;
            default:     rd_data_c = 8'h00;
        endcase
    end

    // Synchroniser, shared prescaler and two-strobe agreement filter
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sync1  <= 8'h00;
            sync2  <= 8'h00;
            presc  <= '0;
            samp   <= 8'h00;
            filt_q <= 8'h00;
            filt_d <= 8'h00;
        end else begin
            sync1  <= I_irq;
            sync2  <= sync1;
            presc  <= strobe_c ? '0 : presc + PW'(1);
            filt_d <= filt_c;
            if (strobe_c) begin
                samp   <= sync2;
                filt_q <= ((sync2 ~^ samp) & sync2) | ((sync2 ^ samp) & filt_q);
            end
        end
    end

    // Bus handshake, control registers and pending capture
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ACK_O       <= 1'b0;
            DAT_O       <= 8'h00;
            O_interrupt <= 1'b0;
            pending     <= 8'h00;
            enable      <= 8'h00;
            edge_mode   <= 8'hFF;
        end else begin
            ACK_O       <= take_c;
            O_interrupt <= |(pending & enable);
            // Edge mode: a new rise wins over a same-cycle W1C
            pending     <= (edge_mode & (rise_c | (pending & ~clr_c))) | (~edge_mode & filt_c);
            if (take_c && !WE_I) begin
                DAT_O <= rd_data_c;
            end
            if (take_c && WE_I) begin
                case (ADR_I)
                    ADR_ENABLE: enable    <= DAT_I;
                    ADR_EDGE:   edge_mode <= DAT_I;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_wb8.sv
// Randomised and directed bench for irq_wb8 against a cycle-level reference model.
// Small debounce period so filter behaviour is reachable in a short run.
module tb_irq_wb8;

    localparam int unsigned DB  = 4;
    localparam logic [7:0]  DBM = 8'h01;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic [1:0] ADR_I = 2'd0;
    logic [7:0] DAT_I = 8'h00;
    logic       STB_I = 1'b0;
    logic       WE_I  = 1'b0;
    logic [7:0] DAT_O;
    logic       ACK_O;
    logic [7:0] I_irq = 8'h00;
    logic       O_interrupt;

    irq_wb8 #(.DEBOUNCE_CYCLES(DB), .DEBOUNCE_MASK(DBM)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
        .STB_I(STB_I), .WE_I(WE_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
        .I_irq(I_irq), .O_interrupt(O_interrupt)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: input history, strobe-sample agreement, register rules
    logic [7:0]  m_seen[$];
    int unsigned m_cyc;
    logic [7:0]  m_last_strobe, m_deb, m_lvl_prev;
    logic [7:0]  m_pend, m_en, m_edge, m_dat;
    logic        m_ack, m_int;

    task automatic model_reset();
        m_seen.delete();
        m_cyc = 0;
        m_last_strobe = 8'h00; m_deb = 8'h00; m_lvl_prev = 8'h00;
        m_pend = 8'h00; m_en = 8'h00; m_edge = 8'hFF;
        m_dat = 8'h00; m_ack = 1'b0; m_int = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] s2, lvl, rise, clr, n_pend, rd;
        bit strobe, take;
        s2     = (m_seen.size() >= 2) ? m_seen[1] : 8'h00;
        strobe = ((m_cyc % DB) == DB - 1);
        lvl    = (m_deb & DBM) | (s2 & ~DBM);
        rise   = lvl & ~m_lvl_prev;
        take   = STB_I && !m_ack;
        clr    = (take && WE_I && ADR_I == 2'd1) ? DAT_I : 8'h00;
        for (int i = 0; i < 8; i++)
            n_pend[i] = m_edge[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : lvl[i];
        m_int = |(m_pend & m_en);
        case (ADR_I)
            2'd0: rd = lvl;
            2'd1: rd = m_pend;
            2'd2: rd = m_en;
            default: rd = m_edge;
        endcase
        if (take && !WE_I) m_dat = rd;
        if (take && WE_I && ADR_I == 2'd2) m_en = DAT_I;
        if (take && WE_I && ADR_I == 2'd3) m_edge = DAT_I;
        m_ack  = take;
        m_pend = n_pend;
        if (strobe) begin
            for (int i = 0; i < 8; i++) begin
                if (s2[i] == m_last_strobe[i]) m_deb[i] = s2[i];
                m_last_strobe[i] = s2[i];
            end
        end
        m_lvl_prev = lvl;
        m_seen.push_front(I_irq);
        if (m_seen.size() > 2) void'(m_seen.pop_back());
        m_cyc++;
    endtask

    always @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) model_reset();
        else        model_step();
    end

    // Every cycle: outputs against the model
    always @(negedge CLK_I) begin
        if (RST_I) begin
            check_eq("ack", 8'(ACK_O), 8'(m_ack));
            check_eq("dat", DAT_O, m_dat);
            check_eq("irq_out", 8'(O_interrupt), 8'(m_int));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        STB_I = 1'b1; WE_I = 1'b1; ADR_I = a; DAT_I = d;
        @(negedge CLK_I);
        STB_I = 1'b0; WE_I = 1'b0;
        @(negedge CLK_I);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = a;
        @(negedge CLK_I);
        d = DAT_O;
        STB_I = 1'b0;
        @(negedge CLK_I);
    endtask

    initial begin
        logic [7:0] rd;
        int first;

        // Reset state
        @(negedge CLK_I);
        check_eq("rst_ack", 8'(ACK_O), 8'h00);
        check_eq("rst_dat", DAT_O, 8'h00);
        check_eq("rst_int", 8'(O_interrupt), 8'h00);
        RST_I = 1'b1;
        tick(1);
        bus_read(2'd3, rd); check_eq("rst_edge", rd, 8'hFF);
        bus_read(2'd2, rd); check_eq("rst_enable", rd, 8'h00);
        bus_read(2'd1, rd); check_eq("rst_pending", rd, 8'h00);

        // Edge capture on a non-debounced source
        bus_write(2'd2, 8'h10);
        I_irq[4] = 1'b1;
        tick(1); I_irq[4] = 1'b0;
        tick(2); check_eq("edge_int_n2", 8'(O_interrupt), 8'h00);
        tick(1); check_eq("edge_int_n3", 8'(O_interrupt), 8'h01);
        bus_read(2'd1, rd); check_eq("edge_pending", rd, 8'h10);
        bus_write(2'd1, 8'h10);
        check_eq("w1c_int", 8'(O_interrupt), 8'h00);

        // W1C landing on the same edge as a new rise
        I_irq[4] = 1'b1;
        tick(2);
        bus_write(2'd1, 8'h10);
        bus_read(2'd1, rd); check_eq("set_wins", rd, 8'h10);
        I_irq[4] = 1'b0;
        bus_write(2'd1, 8'h10);
        bus_read(2'd1, rd); check_eq("set_wins_clr", rd, 8'h00);

        // Debounced source: short glitch is filtered
        I_irq[0] = 1'b1; tick(3); I_irq[0] = 1'b0;
        tick(12);
        bus_read(2'd1, rd); check_eq("glitch_pending", rd, 8'h00);
        bus_read(2'd0, rd); check_eq("glitch_level", rd, 8'h00);

        // Debounced source: sustained level propagates
        bus_write(2'd2, 8'h11);
        I_irq[0] = 1'b1;
        first = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK_I);
            if (O_interrupt && first < 0) first = c;
        end
        I_irq[0] = 1'b0;
        check_eq("deb_within12", (first >= 1 && first <= 12) ? 8'h01 : 8'h00, 8'h01);
        bus_read(2'd1, rd); check_eq("deb_pending", rd, 8'h01);
        bus_write(2'd1, 8'h01);
        bus_read(2'd1, rd); check_eq("deb_cleared", rd, 8'h00);

        // Level mode on the debounced source
        bus_write(2'd3, 8'hFE);
        I_irq[0] = 1'b1; tick(16);
        bus_read(2'd1, rd); check_eq("lvl_pending", rd, 8'h01);
        bus_write(2'd1, 8'h01);
        bus_read(2'd1, rd); check_eq("lvl_no_w1c", rd, 8'h01);
        I_irq[0] = 1'b0; tick(16);
        bus_read(2'd1, rd); check_eq("lvl_follow", rd, 8'h00);
        bus_write(2'd3, 8'hFF);

        // Held strobe: ack every other cycle, one write per access
        STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd2;
        for (int k = 0; k < 6; k++) begin
            DAT_I = 8'h20 + 8'(k);
            @(negedge CLK_I);
            check_eq("held_ack", 8'(ACK_O), (k % 2 == 0) ? 8'h01 : 8'h00);
        end
        STB_I = 1'b0; WE_I = 1'b0;
        tick(1);
        bus_read(2'd2, rd); check_eq("held_enable", rd, 8'h24);

        // LEVEL is read-only
        I_irq = 8'hA6; tick(3);
        bus_read(2'd0, rd); check_eq("level_read", rd, 8'hA6);
        bus_write(2'd0, 8'h00);
        bus_read(2'd0, rd); check_eq("level_ro", rd, 8'hA6);
        I_irq = 8'h00; tick(3);

        // Random traffic against the model
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) I_irq[7:1] = I_irq[7:1] ^ 7'($urandom);
            if ($urandom_range(0, 9) == 0) I_irq[0] = ~I_irq[0];
            case ($urandom_range(0, 3))
                0: tick(1 + int'($urandom_range(0, 2)));
                1: bus_read(2'($urandom), rd);
                default: bus_write(2'($urandom), 8'($urandom));
            endcase
        end

        // Asynchronous reset in the middle of an access
        bus_write(2'd2, 8'hFF);
        bus_write(2'd3, 8'h00);
        I_irq = 8'hFE; tick(4);
        check_eq("pre_rst_int", 8'(O_interrupt), 8'h01);
        STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd2; DAT_I = 8'h00;
        @(negedge CLK_I);
        #2 RST_I = 1'b0;
        #1;
        check_eq("mid_rst_ack", 8'(ACK_O), 8'h00);
        check_eq("mid_rst_dat", DAT_O, 8'h00);
        check_eq("mid_rst_int", 8'(O_interrupt), 8'h00);
        STB_I = 1'b0; WE_I = 1'b0; I_irq = 8'h00;
        tick(2);
        RST_I = 1'b1;
        tick(1);
        bus_read(2'd3, rd); check_eq("post_rst_edge", rd, 8'hFF);
        bus_read(2'd2, rd); check_eq("post_rst_enable", rd, 8'h00);
        bus_read(2'd1, rd); check_eq("post_rst_pending", rd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
